// File: rtl/m68k_bus_decoder.sv
// m68k_bus_decoder: registered 68000 address decoder with per-region wait states, ready stretching and DTACK/BERR.
// Define M68K_BUS_DECODER_BUS_ERR_EN to raise BERR on unmapped accesses and on ready timeouts.
module m68k_bus_decoder #(
  parameter int NUM_REGIONS = 16,
  parameter logic [NUM_REGIONS*24-1:0] REGION_START = '0,
  parameter logic [NUM_REGIONS*24-1:0] REGION_END = '0,
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = '0,
  parameter logic [NUM_REGIONS-1:0] REGION_READY = '0,
  parameter int DEFAULT_WAIT = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  input logic [23:0] m68k_a,
  input logic m68k_as_n,
  input logic m68k_rw,
  input logic [NUM_REGIONS-1:0] region_ready,
  output logic [NUM_REGIONS-1:0] cs,
  output logic m68k_dtack_n,
  output logic m68k_berr_n,
  output logic busy,
  output logic [4:0] region_idx,
  output logic cycle_rw
);
`ifdef M68K_BUS_DECODER_BUS_ERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif
  localparam logic [127:0] WAITS = 128'(REGION_WAIT);
  localparam logic [31:0] RDY_MASK = 32'(REGION_READY);
  localparam logic [7:0] TMAX = 8'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, ERR} state_t;
  state_t state, state_d;
  logic [23:0] addr, addr_d;
  logic unmapped, unmapped_d;
  logic [3:0] wcnt, wcnt_d;
  logic [7:0] tcnt, tcnt_d;
  logic [NUM_REGIONS-1:0] cs_d;
  logic dtack_d, berr_d, busy_d, rw_d;
  logic [4:0] idx_d, hit_idx;
  logic hit, rdy_ok;
  logic [31:0] rdy_in;
  assign rdy_in = 32'(region_ready);
  assign rdy_ok = !RDY_MASK[region_idx] || rdy_in[region_idx];
  // Range test as one unsigned compare of offsets; descending scan lets the lowest index win.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (REGION_START[24*i +: 24] <= REGION_END[24*i +: 24] &&
          addr - REGION_START[24*i +: 24] <= REGION_END[24*i +: 24] - REGION_START[24*i +: 24]) begin
        hit = 1'b1;
        hit_idx = 5'(i);
      end
  end
  always_comb begin
    state_d = state;
    addr_d = addr;
    unmapped_d = unmapped;
    wcnt_d = wcnt;
    tcnt_d = tcnt;
    cs_d = cs;
    dtack_d = m68k_dtack_n;
    berr_d = m68k_berr_n;
    busy_d = busy;
    idx_d = region_idx;
    rw_d = cycle_rw;
    case (state)
      IDLE: if (!m68k_as_n) begin
        state_d = DECODE;
        addr_d = m68k_a;
        rw_d = m68k_rw;
        busy_d = 1'b1;
      end
      DECODE: begin
        state_d = WAIT;
        unmapped_d = !hit;
        cs_d = hit ? NUM_REGIONS'(1) << hit_idx : '0;
        idx_d = hit ? hit_idx : 5'd0;
        wcnt_d = hit ? WAITS[{hit_idx, 2'b00} +: 4] : BERR_EN ? 4'd0 : 4'(DEFAULT_WAIT);
        tcnt_d = '0;
      end
      WAIT: begin
        wcnt_d = wcnt != 0 ? wcnt - 4'd1 : wcnt;
        tcnt_d = tcnt == TMAX ? tcnt : tcnt + 8'd1;
        if (wcnt == 0 && (unmapped ? !BERR_EN : rdy_ok)) begin
          state_d = ACK;
          dtack_d = 1'b0;
        end else if (BERR_EN && (unmapped || RDY_MASK[region_idx]) && tcnt_d == TMAX) begin
          state_d = ERR;
          berr_d = 1'b0;
          cs_d = '0;
        end
      end
      default: ;
    endcase
    // Strobe released: ends ACK/ERR normally, aborts DECODE/WAIT without DTACK.
    if (state != IDLE && m68k_as_n) begin
      state_d = IDLE;
      unmapped_d = 1'b0;
      wcnt_d = '0;
      tcnt_d = '0;
      cs_d = '0;
      dtack_d = 1'b1;
      berr_d = 1'b1;
      busy_d = 1'b0;
      idx_d = '0;
      rw_d = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      unmapped <= 1'b0;
      wcnt <= '0;
      tcnt <= '0;
      cs <= '0;
      m68k_dtack_n <= 1'b1;
      m68k_berr_n <= 1'b1;
      busy <= 1'b0;
      region_idx <= '0;
      cycle_rw <= 1'b1;
    end else begin
      state <= state_d;
      addr <= addr_d;
      unmapped <= unmapped_d;
      wcnt <= wcnt_d;
      tcnt <= tcnt_d;
      cs <= cs_d;
      m68k_dtack_n <= dtack_d;
      m68k_berr_n <= berr_d;
      busy <= busy_d;
      region_idx <= idx_d;
      cycle_rw <= rw_d;
    end
endmodule

// File: tb/tb_m68k_bus_decoder.sv
// tb_m68k_bus_decoder: vector table, corner sequences and random cycles checked against a region-table model.
// Expectations adapt when M68K_BUS_DECODER_BUS_ERR_EN is defined.
module tb_m68k_bus_decoder;
  localparam int NR = 8;
  localparam int DW = 2;
  localparam int TMO = 8;
  localparam logic [23:0] LO [NR] = '{24'h000000, 24'h070000, 24'h0e0000, 24'h100000,
                                      24'h200000, 24'h0e0040, 24'h300000, 24'h400000};
  localparam logic [23:0] HI [NR] = '{24'h03ffff, 24'h073fff, 24'h0e00ff, 24'h10ffff,
                                      24'h2fffff, 24'h0e0041, 24'h3000ff, 24'h400003};
  localparam logic [NR*4-1:0] WP = {4'd0, 4'd5, 4'd0, 4'd3, 4'd15, 4'd1, 4'd2, 4'd0};
  localparam logic [NR-1:0] RDY = 8'b0101_0001;
  function automatic logic [NR*24-1:0] pack24(input bit hi);
    logic [NR*24-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[24*i +: 24] = hi ? HI[i] : LO[i];
    return r;
  endfunction
  logic clk = 1'b0, reset, m68k_as_n, m68k_rw;
  logic [23:0] m68k_a;
  logic [NR-1:0] region_ready, cs;
  logic m68k_dtack_n, m68k_berr_n, busy, cycle_rw;
  logic [4:0] region_idx;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  m68k_bus_decoder #(
    .NUM_REGIONS(NR), .REGION_START(pack24(1'b0)), .REGION_END(pack24(1'b1)),
    .REGION_WAIT(WP), .REGION_READY(RDY), .DEFAULT_WAIT(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .m68k_a(m68k_a), .m68k_as_n(m68k_as_n), .m68k_rw(m68k_rw),
    .region_ready(region_ready), .cs(cs), .m68k_dtack_n(m68k_dtack_n), .m68k_berr_n(m68k_berr_n),
    .busy(busy), .region_idx(region_idx), .cycle_rw(cycle_rw)
  );
  typedef struct {logic [23:0] a; logic rw; int d; int idx; int ack;} vec_t;
  vec_t vt [16];
  function automatic int find(input logic [23:0] a);
    for (int i = 0; i < NR; i++) if (a >= LO[i] && a <= HI[i]) return i;
    return -1;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "/idle"}, {cs, m68k_dtack_n, m68k_berr_n, busy, region_idx, cycle_rw},
        {NR'(0), 3'b110, 5'd0, 1'b1});
  endtask
  // One full bus cycle; ack is the DTACK edge the default build should produce.
  task automatic run(input string nm, input logic [23:0] a, input logic rw, input int d,
                     input int idx, input int ack);
    bit hit, err;
    int got;
    logic [NR-1:0] ecs;
    hit = idx >= 0;
    err = 1'b0;
`ifdef M68K_BUS_DECODER_BUS_ERR_EN
    err = !hit || (RDY[hit ? idx : 0] && ack > 1 + TMO);
`endif
    ecs = hit ? NR'(1) << idx : '0;
    m68k_a = a;
    m68k_rw = rw;
    m68k_as_n = 1'b0;
    region_ready = '1;
    if (hit && d > 0) region_ready[idx] = 1'b0;
    cyc();
    chk({nm, "/busy"}, busy, 1);
    chk({nm, "/cycle_rw"}, cycle_rw, rw);
    m68k_a = ~a;
    got = 0;
    for (int e = 1; e <= 40 && got == 0; e++) begin
      cyc();
      if (e == 1) begin
        chk({nm, "/cs_e1"}, cs, ecs);
        chk({nm, "/region_idx"}, region_idx, hit ? idx : 0);
      end
      if (!m68k_dtack_n || !m68k_berr_n) got = e;
      if (hit && e == 1 + d) region_ready[idx] = 1'b1;
    end
    chk({nm, "/term_edge"}, got, err ? 1 + TMO : ack);
    chk({nm, "/dtack_berr"}, {m68k_dtack_n, m68k_berr_n}, err ? 2'b10 : 2'b01);
    chk({nm, "/cs_term"}, cs, err ? '0 : ecs);
    cyc();
    chk({nm, "/held"}, {m68k_dtack_n, m68k_berr_n, cs}, {err ? 2'b10 : 2'b01, err ? '0 : ecs});
    m68k_as_n = 1'b1;
    cyc();
    chk_idle(nm);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    bit seen;
    reset = 1'b1;
    m68k_as_n = 1'b1;
    m68k_a = '0;
    m68k_rw = 1'b1;
    region_ready = '1;
    cyc();
    cyc();
    chk_idle("reset");
    reset = 1'b0;
    cyc();
    chk_idle("post_reset");
    vt = '{'{24'h001234, 1'b1, 0, 0, 2}, '{24'h070010, 1'b1, 0, 1, 4},
           '{24'h001234, 1'b0, 10, 0, 12}, '{24'h0e0040, 1'b1, 0, 2, 3},
           '{24'h0e0041, 1'b0, 0, 2, 3}, '{24'h500000, 1'b1, 0, -1, 4},
           '{24'h200010, 1'b1, 3, 4, 5}, '{24'h2ffffe, 1'b0, 6, 4, 8},
           '{24'h070000, 1'b0, 5, 1, 4}, '{24'h073fff, 1'b1, 0, 1, 4},
           '{24'h074000, 1'b1, 0, -1, 4}, '{24'h03ffff, 1'b0, 0, 0, 2},
           '{24'h040000, 1'b1, 0, -1, 4}, '{24'h400003, 1'b1, 2, 7, 2},
           '{24'h100000, 1'b0, 0, 3, 17}, '{24'h3000ff, 1'b1, 9, 6, 11}};
    for (int i = 0; i < 16; i++)
      run($sformatf("vec%0d", i), vt[i].a, vt[i].rw, vt[i].d, vt[i].idx, vt[i].ack);
    // Abort during WAIT of the wait-15 region.
    m68k_a = 24'h100000;
    m68k_as_n = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      cyc();
      if (!m68k_dtack_n) seen = 1'b1;
    end
    chk("abort/busy_cs", {busy, cs}, {1'b1, NR'(8)});
    m68k_as_n = 1'b1;
    cyc();
    if (!m68k_dtack_n) seen = 1'b1;
    chk_idle("abort_wait");
    cyc();
    if (!m68k_dtack_n) seen = 1'b1;
    chk("abort/no_dtack", seen, 0);
    // Abort in DECODE.
    m68k_a = 24'h070010;
    m68k_as_n = 1'b0;
    cyc();
    m68k_as_n = 1'b1;
    cyc();
    chk_idle("abort_decode");
    // Reset while in ACK.
    m68k_a = 24'h001234;
    m68k_as_n = 1'b0;
    repeat (3) cyc();
    chk("rst_ack/dtack", m68k_dtack_n, 0);
    reset = 1'b1;
    cyc();
    chk_idle("rst_ack");
    reset = 1'b0;
    m68k_as_n = 1'b1;
    cyc();
    chk_idle("rst_ack_after");
    for (int k = 0; k < 40; k++) begin
      logic [23:0] a;
      int r, idx, d, w, ack;
      r = $urandom_range(0, NR);
      if (r == NR) a = 24'($urandom);
      else a = LO[r] + 24'($urandom_range(0, int'(HI[r] - LO[r])));
      d = $urandom_range(0, 6);
      idx = find(a);
      if (idx < 0) ack = 2 + DW;
      else begin
        w = int'(WP[4*idx +: 4]);
        ack = 2 + ((RDY[idx] && d > w) ? d : w);
      end
      run($sformatf("rand%0d", k), a, 1'($urandom), d, idx, ack);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/m68k_bus_decoder.md
Name: m68k_bus_decoder

Overview:
- Parametrised, registered 68000 address decoder with per-region wait states, external-ready stretching and DTACK/BERR generation.
- Region table (start, end, wait, ready-use) is supplied by parameters. The same block serves every PCB variant's main CPU map.
- Sits between the fx68k bus and the core's RAM/ROM/IO selects. Drives one-hot chip selects and the CPU's DTACK_n/BERR_n.

Parameters:
- NUM_REGIONS, 16, number of decoded regions (1..32)
- REGION_START, 0, packed NUM_REGIONS*24 bits; region i start byte address at [24*i +: 24]
- REGION_END, 0, packed NUM_REGIONS*24 bits; region i inclusive end address
- REGION_WAIT, 0, packed NUM_REGIONS*4 bits; extra wait clocks before DTACK (0..15)
- REGION_READY, 0, NUM_REGIONS bits; bit i=1 means region i also waits for region_ready[i]
- DEFAULT_WAIT, 2, wait clocks for unmapped accesses (BUS_ERR_EN off)
- TIMEOUT, 255, cycle-length limit in clocks; counter width is 8 bits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m68k_a  in  24  CPU byte address
- m68k_as_n  in  1  address strobe, active low
- m68k_rw  in  1  1=read, 0=write
- region_ready  in  NUM_REGIONS  per-region ready from slow targets (SDRAM ROM etc.)
- cs  out  NUM_REGIONS  registered one-hot chip selects
- m68k_dtack_n  out  1  data acknowledge, active low
- m68k_berr_n  out  1  bus error, active low
- busy  out  1  high while a bus cycle is being processed
- region_idx  out  5  index of the currently selected region (valid while cs!=0)
- cycle_rw  out  1  m68k_rw latched at cycle start

Behaviour:
- Reset: one clk with reset=1 forces state IDLE.
  - Outputs: cs=0, m68k_dtack_n=1, m68k_berr_n=1, busy=0, region_idx=0, cycle_rw=1, counters=0.
  - Reset mid-cycle aborts the cycle immediately.
- Edge numbering: edge 0 is the first clk edge sampling m68k_as_n=0 in IDLE.
- States: IDLE, DECODE, WAIT, ACK, ERR.
- IDLE:
  - On m68k_as_n=0, latch m68k_a and m68k_rw, set busy=1, go DECODE.
  - Address changes after edge 0 are ignored.
- DECODE (edge 1):
  - Region i matches when start_i <= addr <= end_i.
  - On overlapping matches, the lowest index wins.
  - On a match: cs[idx]=1, region_idx=idx, wait counter=REGION_WAIT[idx], timeout counter=0, go WAIT.
  - With no match: cs=0, wait counter=DEFAULT_WAIT, go WAIT flagged unmapped.
- WAIT:
  - Wait counter decrements each clk while nonzero.
  - Leave for ACK when the counter is 0 and (REGION_READY[idx]=0 or region_ready[idx]=1).
  - Unmapped cycles: see Optional Feature.
  - m68k_dtack_n goes low on the edge entering ACK. With wait W and ready already high, DTACK is low after edge 2+W.
  - Timeout counter increments every clk in WAIT and saturates at TIMEOUT.
- ACK:
  - Hold dtack_n=0 and cs while m68k_as_n=0.
  - On the first edge sampling m68k_as_n=1: cs=0, dtack_n=1, busy=0, go IDLE.
  - A new cycle needs as_n sampled high at least once; back-to-back strobes are separated by one IDLE clk.
- Abort: m68k_as_n=1 sampled in DECODE or WAIT returns to IDLE on that edge, clearing cs and busy; no DTACK is issued.
- ERR:
  - m68k_berr_n=0, cs=0, dtack_n=1, held until m68k_as_n=1 is sampled, then IDLE.
- region_ready is ignored for regions whose REGION_READY bit is 0.
- Ready arriving on the same edge the counter reaches 0 counts as satisfied.

Optional Feature:
- Macro: M68K_BUS_DECODER_BUS_ERR_EN
- Defined:
  - Unmapped cycles skip DEFAULT_WAIT and go to ERR when the timeout counter reaches TIMEOUT.
  - A mapped region whose ready does not arrive within TIMEOUT clocks of edge 1 also goes to ERR (cs dropped).
- Undefined:
  - Unmapped cycles reach ACK after DEFAULT_WAIT, with cs=0 (open bus).
  - Ready waits are unbounded.
  - m68k_berr_n is tied 1; the ERR state is unused.

Test Plan:
- Regions {0: 000000-03ffff wait 0; 1: 070000-073fff wait 2}, read 0x001234 -> cs=0x0001 after edge 1, dtack_n=0 after edge 2, both released one clk after as_n high.
- Read 0x070010 -> cs[1] after edge 1, dtack_n=0 after edge 4; region_idx=1, cycle_rw=1.
- Region 0 with REGION_READY[0]=1, ready raised 10 clks after edge 1 -> dtack_n=0 on the edge ready is sampled, not before.
- Overlapping regions 2 (0e0000-0e00ff) and 5 (0e0040-0e0041), access 0x0e0040 -> only cs[2]=1.
- Unmapped 0x500000:
  - BUS_ERR_EN defined, TIMEOUT=8 -> berr_n=0 after 8 WAIT clks, dtack_n stays 1.
  - Undefined -> dtack_n=0 after edge 4, cs=0.
- as_n deasserted during WAIT of wait-15 region, and reset asserted mid-ACK -> both return to IDLE with all outputs at reset values, no DTACK pulse.
